// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
// Two-road intersection controller with pedestrian crossing requests and a
// flashing-yellow night mode.
//
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   rst_n       - asynchronous active-low reset (forces INIT, both roads red)
//   ena         - advance enable; 0 freezes state, counters and requests
//   night_mode  - request for flashing-yellow operation
//   ped_req[1:0]- bit i requests a pedestrian crossing of road i (0=A, 1=B)
//   lights_a    - road A lamps {red, yellow, green}
//   lights_b    - road B lamps {red, yellow, green}
//   ped_walk    - bit i is the walk indication for crossing road i
//   phase       - current state encoding, for debug
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN     = 20,
    parameter int T_MIN_GREEN = 5,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int BLINK_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       night_mode,
    input  logic [1:0] ped_req,
    output logic [2:0] lights_a,
    output logic [2:0] lights_b,
    output logic [1:0] ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_A_GRN = 3'd1,
        ST_A_YEL = 3'd2,
        ST_AR_AB = 3'd3,
        ST_B_GRN = 3'd4,
        ST_B_YEL = 3'd5,
        ST_AR_BA = 3'd6,
        ST_NIGHT = 3'd7
    } state_t;

    localparam int CNT_MAX = (2 ** CNT_W) - 1;
    localparam int BLK_W   = CNT_W + 1;

    // Terminal counts: a timed state leaves on the cycle its counter shows
    // duration-1, so each state lasts exactly its duration in enabled cycles.
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GRN_LAST    = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLK_W-1:0] BLK_HALF    = BLK_W'(BLINK_HALF);

    // Reject parameter sets the counters cannot represent.
    if ((T_GREEN < 1) || (T_GREEN > CNT_MAX) ||
        (T_MIN_GREEN < 1) || (T_MIN_GREEN > CNT_MAX) ||
        (T_YELLOW < 1) || (T_YELLOW > CNT_MAX) ||
        (T_ALLRED < 1) || (T_ALLRED > CNT_MAX) ||
        (BLINK_HALF < 1) || (BLINK_HALF > CNT_MAX) ||
        (T_MIN_GREEN > T_GREEN)) begin : g_param_err
        $error("traffic_intersection_ctrl: illegal duration parameters");
    end

    state_t           state_r, state_s, succ_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [BLK_W-1:0] blink_r, blink_s;
    logic [1:0]       pend_r, pend_s, pend_eff_s;
    logic [1:0]       walk_r, walk_s;
    logic [2:0]       la_r, lb_r, la_s, lb_s;
    logic             done_s;
    logic             yel_on_s;

    // Next-state, counter, request latch and lamp decode of the next state.
    always_comb begin
        state_s    = state_r;
        succ_s     = ST_INIT;
        cnt_s      = cnt_r;
        blink_s    = blink_r;
        pend_s     = pend_r;
        walk_s     = 2'b00;
        done_s     = 1'b0;
        yel_on_s   = 1'b0;
        la_s       = 3'b100;
        lb_s       = 3'b100;
        // A request seen this very cycle already counts towards shortening.
        pend_eff_s = pend_r | ped_req;

        case (state_r)
            ST_INIT:  succ_s = night_mode ? ST_NIGHT : ST_A_GRN;
            ST_A_GRN: succ_s = ST_A_YEL;
            ST_A_YEL: succ_s = ST_AR_AB;
            ST_AR_AB: succ_s = night_mode ? ST_NIGHT : ST_B_GRN;
            ST_B_GRN: succ_s = ST_B_YEL;
            ST_B_YEL: succ_s = ST_AR_BA;
            ST_AR_BA: succ_s = night_mode ? ST_NIGHT : ST_A_GRN;
            ST_NIGHT: succ_s = ST_INIT;
            default:  succ_s = ST_INIT;
        endcase

        case (state_r)
            ST_INIT, ST_AR_AB, ST_AR_BA: done_s = (cnt_r == ALLRED_LAST);
            ST_A_GRN: done_s = (cnt_r == GRN_LAST) ||
                               (pend_eff_s[0] && (cnt_r >= MIN_LAST));
            ST_B_GRN: done_s = (cnt_r == GRN_LAST) ||
                               (pend_eff_s[1] && (cnt_r >= MIN_LAST));
            ST_A_YEL, ST_B_YEL: done_s = (cnt_r == YEL_LAST);
            ST_NIGHT: done_s = ~night_mode;
            default:  done_s = 1'b1;
        endcase

        if (ena) begin
            pend_s = pend_r | ped_req;
            if (done_s) begin
                state_s = succ_s;
                cnt_s   = {CNT_W{1'b0}};
                blink_s = {BLK_W{1'b0}};
                // Serving clears the latch, but a request in the same cycle
                // stays pending for the next opposite green.
                if (succ_s == ST_B_GRN) begin
                    pend_s[0] = ped_req[0];
                end else if (succ_s == ST_A_GRN) begin
                    pend_s[1] = ped_req[1];
                end else begin
                    pend_s = pend_r | ped_req;
                end
            end else begin
                cnt_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_W'(1));
                if (state_r == ST_NIGHT) begin
                    blink_s = (blink_r == BLK_LAST) ? {BLK_W{1'b0}}
                                                    : (blink_r + BLK_W'(1));
                end else begin
                    blink_s = {BLK_W{1'b0}};
                end
            end
        end else begin
            state_s = state_r;
        end

        // Walk is captured from the latch on green entry and held all green.
        case (state_s)
            ST_B_GRN: walk_s = {1'b0, (state_r == ST_B_GRN) ? walk_r[0] : pend_r[0]};
            ST_A_GRN: walk_s = {(state_r == ST_A_GRN) ? walk_r[1] : pend_r[1], 1'b0};
            default:  walk_s = 2'b00;
        endcase

        yel_on_s = (blink_s < BLK_HALF);
        case (state_s)
            ST_A_GRN: begin la_s = 3'b001; lb_s = 3'b100; end
            ST_A_YEL: begin la_s = 3'b010; lb_s = 3'b100; end
            ST_B_GRN: begin la_s = 3'b100; lb_s = 3'b001; end
            ST_B_YEL: begin la_s = 3'b100; lb_s = 3'b010; end
            ST_NIGHT: begin
                la_s = {1'b0, yel_on_s, 1'b0};
                lb_s = {1'b0, yel_on_s, 1'b0};
            end
            default:  begin la_s = 3'b100; lb_s = 3'b100; end
        endcase
    end

    // State, counters, request latch and registered lamp outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= {CNT_W{1'b0}};
            blink_r <= {BLK_W{1'b0}};
            pend_r  <= 2'b00;
            walk_r  <= 2'b00;
            la_r    <= 3'b100;
            lb_r    <= 3'b100;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            blink_r <= blink_s;
            pend_r  <= pend_s;
            walk_r  <= walk_s;
            la_r    <= la_s;
            lb_r    <= lb_s;
        end
    end

    assign lights_a = la_r;
    assign lights_b = lb_r;
    assign ped_walk = walk_r;
    assign phase    = state_r;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for traffic_intersection_ctrl. A driver issues one cycle of
// stimulus at a time, advances a phase-table reference model and queues the
// expected outputs; a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

    localparam int TG   = 20;
    localparam int TMIN = 5;
    localparam int TY   = 3;
    localparam int TAR  = 2;
    localparam int BH   = 4;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       night_mode = 1'b0;
    logic [1:0] ped_req = 2'b00;
    logic [2:0] lights_a, lights_b, phase;
    logic [1:0] ped_walk;

    traffic_intersection_ctrl #(
        .CNT_W(8), .T_GREEN(TG), .T_MIN_GREEN(TMIN),
        .T_YELLOW(TY), .T_ALLRED(TAR), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .night_mode(night_mode),
        .ped_req(ped_req), .lights_a(lights_a), .lights_b(lights_b),
        .ped_walk(ped_walk), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] la;
        logic [2:0] lb;
        logic [1:0] pw;
        logic [2:0] ph;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase index, elapsed cycles, blink position, requests.
    // Phases: 0 INIT,1 A green,2 A yellow,3 all-red,4 B green,5 B yellow,
    // 6 all-red,7 night.
    int       m_ph, m_cnt, m_blink;
    bit [1:0] m_pend, m_walk;
    int       nxt [8] = '{1, 2, 3, 4, 5, 6, 1, 0};

    function automatic int dur(int p);
        if (p == 1 || p == 4) return TG;
        if (p == 2 || p == 5) return TY;
        return TAR;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_cnt = 0; m_blink = 0; m_pend = 2'b00; m_walk = 2'b00;
    endtask

    task automatic m_step(bit e, bit n, bit [1:0] p);
        int  lim;
        int  to;
        bit  leave;
        bit  want;
        if (!e) return;
        if (m_ph == 7) begin
            leave = !n;
        end else if (m_ph == 1 || m_ph == 4) begin
            want = (m_ph == 1) ? (m_pend[0] | p[0]) : (m_pend[1] | p[1]);
            lim  = TG;
            if (want) lim = (TMIN > m_cnt + 1) ? TMIN : m_cnt + 1;
            leave = (m_cnt == lim - 1);
        end else begin
            leave = (m_cnt == dur(m_ph) - 1);
        end
        if (leave) begin
            to = nxt[m_ph];
            if (n && (m_ph == 0 || m_ph == 3 || m_ph == 6)) to = 7;
            m_walk = 2'b00;
            if (to == 4) begin m_walk[0] = m_pend[0]; m_pend[0] = 1'b0; end
            if (to == 1) begin m_walk[1] = m_pend[1]; m_pend[1] = 1'b0; end
            m_ph = to; m_cnt = 0; m_blink = 0;
        end else begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (m_ph == 7) m_blink = (m_blink + 1) % (2 * BH);
        end
        m_pend = m_pend | p;
    endtask

    function automatic exp_t m_out();
        exp_t o;
        bit   yel;
        yel  = (m_ph == 7) && (m_blink < BH);
        o.la = {!(m_ph == 1 || m_ph == 2 || m_ph == 7), (m_ph == 2) || yel, m_ph == 1};
        o.lb = {!(m_ph == 4 || m_ph == 5 || m_ph == 7), (m_ph == 5) || yel, m_ph == 4};
        o.pw = m_walk;
        o.ph = 3'(m_ph);
        return o;
    endfunction

    // One clock of stimulus; expectation is for the following rising edge.
    task automatic cyc(bit r, bit e, bit n, bit [1:0] p);
        @(negedge clk);
        rst_n = r; ena = e; night_mode = n; ped_req = p;
        if (!r) m_reset();
        else    m_step(e, n, p);
        exp_q.push_back(m_out());
    endtask

    task automatic run(int k, bit n);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b1, n, 2'b00);
    endtask

    task automatic run_until(int ph, int cnt, bit n, string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_ph == ph && m_cnt == cnt) begin ok = 1'b1; break; end
            cyc(1'b1, 1'b1, n, 2'b00);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_%s: state %0d/%0d not reached, model at %0d/%0d",
                     tag, ph, cnt, m_ph, m_cnt);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (lights_a !== e.la || lights_b !== e.lb ||
                    ped_walk !== e.pw || phase !== e.ph) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got a=%b b=%b walk=%b phase=%0d exp a=%b b=%b walk=%b phase=%0d",
                             $time, lights_a, lights_b, ped_walk, phase,
                             e.la, e.lb, e.pw, e.ph);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        bit       r, e, n;
        bit [1:0] p;
        m_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 2'b00);

        // Plain cycling, two full periods.
        run(110, 1'b0);

        // Early pedestrian request shortens A green to the minimum.
        run_until(1, 2, 1'b0, "a_grn2");
        cyc(1'b1, 1'b1, 1'b0, 2'b01);
        run(60, 1'b0);

        // Late pedestrian request ends A green on the next edge.
        run_until(1, 12, 1'b0, "a_grn12");
        cyc(1'b1, 1'b1, 1'b0, 2'b01);
        run(60, 1'b0);

        // Night request during B green, blink, then back to day.
        run_until(4, 3, 1'b0, "b_grn");
        run(50, 1'b1);
        run(30, 1'b0);

        // Freeze in A yellow with ignored requests.
        run_until(2, 1, 1'b0, "a_yel1");
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 2'($urandom_range(1, 3)));
        run(30, 1'b0);

        // Asynchronous reset while a night yellow is lit.
        run_until(7, 1, 1'b1, "night_on");
        @(negedge clk);
        #2;
        rst_n = 1'b0; night_mode = 1'b0;
        #1;
        total++;
        if (lights_a !== 3'b100 || lights_b !== 3'b100 || ped_walk !== 2'b00 || phase !== 3'd0) begin
            bad++;
            $display("FAIL async_reset: got a=%b b=%b walk=%b phase=%0d exp a=100 b=100 walk=00 phase=0",
                     lights_a, lights_b, ped_walk, phase);
        end
        m_reset();
        exp_q.push_back(m_out());
        cyc(1'b0, 1'b1, 1'b0, 2'b00);
        run(30, 1'b0);

        // Randomized traffic.
        n = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) n = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 399) != 0);
            e = ($urandom_range(0, 5) != 0);
            p = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00;
            cyc(r, e, n, p);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
